// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the write-back data cache controller: address field
// geometry, controller state encoding and RV32I load/store width codes.
package cache_pkg;

  localparam int ADDR_BITS       = 32;
  localparam int DATA_BITS       = 32;
  localparam int TAG_BITS        = 23;
  localparam int SET_INDEX_WIDTH = 5;
  localparam int ELEMENT_WORDS   = 4;
  localparam int WORD_SEL_BITS   = 2;
  localparam int BYTE_OFS_BITS   = 2;
  localparam int STAT_BITS       = 32;

  localparam int WORD_LSB  = BYTE_OFS_BITS;
  localparam int INDEX_LSB = WORD_LSB + WORD_SEL_BITS;
  localparam int TAG_LSB   = INDEX_LSB + SET_INDEX_WIDTH;

  localparam logic [WORD_SEL_BITS-1:0] WORD_FIRST = 2'd0;
  localparam logic [WORD_SEL_BITS-1:0] WORD_LAST  = 2'd3;
  localparam logic [WORD_SEL_BITS-1:0] WORD_STEP  = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROBE = 3'd1,
    ST_CHECK = 3'd2,
    ST_WB_RD = 3'd3,
    ST_WB_WR = 3'd4,
    ST_FILL  = 3'd5
  } ctrl_state_e;

  localparam logic [2:0] UBHW_B  = 3'b000;
  localparam logic [2:0] UBHW_H  = 3'b001;
  localparam logic [2:0] UBHW_W  = 3'b010;
  localparam logic [2:0] UBHW_BU = 3'b100;
  localparam logic [2:0] UBHW_HU = 3'b101;

  function automatic logic [ADDR_BITS-1:0] line_word_addr(
    input logic [TAG_BITS-1:0]        tag,
    input logic [SET_INDEX_WIDTH-1:0] idx,
    input logic [WORD_SEL_BITS-1:0]   w
  );
    return {tag, idx, w, 2'b00};
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU, cache-array and main-memory signal bundle seen by the cache controller.
interface cache_ctrl_if;
  import cache_pkg::*;

  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [2:0]           cpu_u_b_h_w;
  logic [DATA_BITS-1:0] cpu_din;
  logic [DATA_BITS-1:0] cpu_dout;
  logic                 cpu_ready;

  logic [ADDR_BITS-1:0] cache_addr;
  logic                 cache_load;
  logic                 cache_store;
  logic                 cache_edit;
  logic                 cache_invalid;
  logic [2:0]           cache_u_b_h_w;
  logic [DATA_BITS-1:0] cache_din;
  logic                 cache_hit;
  logic                 cache_valid;
  logic                 cache_dirty;
  logic [TAG_BITS-1:0]  cache_tag;
  logic [DATA_BITS-1:0] cache_dout;

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata;
  logic                 mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_u_b_h_w, cpu_din,
    output cpu_dout, cpu_ready,
    output cache_addr, cache_load, cache_store, cache_edit, cache_invalid,
    output cache_u_b_h_w, cache_din,
    input  cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_u_b_h_w, cpu_din,
    input  cpu_dout, cpu_ready,
    input  cache_addr, cache_load, cache_store, cache_edit, cache_invalid,
    input  cache_u_b_h_w, cache_din,
    output cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/cache_ctrl_stats.sv
// Hit / miss / writeback event counters for the cache controller.
// Free-running 32-bit counters that wrap.
module cache_ctrl_stats
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hit_evt,
  input  logic                 miss_evt,
  input  logic                 wb_evt,
  output logic [STAT_BITS-1:0] hit_cnt,
  output logic [STAT_BITS-1:0] miss_cnt,
  output logic [STAT_BITS-1:0] wb_cnt
);

  // Hit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= 32'd0;
    end else if (hit_evt) begin
      hit_cnt <= hit_cnt + 32'd1;
    end else begin
      hit_cnt <= hit_cnt;
    end
  end

  // Miss counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt <= 32'd0;
    end else if (miss_evt) begin
      miss_cnt <= miss_cnt + 32'd1;
    end else begin
      miss_cnt <= miss_cnt;
    end
  end

  // Writeback counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cnt <= 32'd0;
    end else if (wb_evt) begin
      wb_cnt <= wb_cnt + 32'd1;
    end else begin
      wb_cnt <= wb_cnt;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller for the 2-way set-associative write-back data cache.
// Optional statistics counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cache_ctrl_if.master         bus,
  output logic [STAT_BITS-1:0] hit_cnt,
  output logic [STAT_BITS-1:0] miss_cnt,
  output logic [STAT_BITS-1:0] wb_cnt
);

  ctrl_state_e                state_r, state_s;
  logic [WORD_SEL_BITS-1:0]   w_r, w_s;
  logic [ADDR_BITS-1:0]       req_addr_r, req_addr_s;
  logic                       req_we_r, req_we_s;
  logic [2:0]                 req_ubhw_r, req_ubhw_s;
  logic [DATA_BITS-1:0]       req_din_r, req_din_s;
  logic [TAG_BITS-1:0]        victim_tag_r, victim_tag_s;
  logic                       retry_r, retry_s;

  logic [TAG_BITS-1:0]        req_tag_s;
  logic [SET_INDEX_WIDTH-1:0] req_idx_s;
  logic [ADDR_BITS-1:0]       wb_addr_s;
  logic [ADDR_BITS-1:0]       fill_addr_s;

  logic                       cpu_ready_s;
  logic [DATA_BITS-1:0]       cpu_dout_s;
  logic [ADDR_BITS-1:0]       cache_addr_s;
  logic                       cache_load_s;
  logic                       cache_store_s;
  logic                       cache_edit_s;
  logic [2:0]                 cache_ubhw_s;
  logic [DATA_BITS-1:0]       cache_din_s;
  logic                       mem_req_s;
  logic                       mem_we_s;
  logic [ADDR_BITS-1:0]       mem_addr_s;
  logic [DATA_BITS-1:0]       mem_wdata_s;

  assign req_tag_s   = req_addr_r[ADDR_BITS-1:TAG_LSB];
  assign req_idx_s   = req_addr_r[TAG_LSB-1:INDEX_LSB];
  assign wb_addr_s   = line_word_addr(victim_tag_r, req_idx_s, w_r);
  assign fill_addr_s = line_word_addr(req_tag_s, req_idx_s, w_r);

  // State register and latched request / victim fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      w_r          <= WORD_FIRST;
      req_addr_r   <= 32'd0;
      req_we_r     <= 1'b0;
      req_ubhw_r   <= 3'b000;
      req_din_r    <= 32'd0;
      victim_tag_r <= 23'd0;
      retry_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      w_r          <= w_s;
      req_addr_r   <= req_addr_s;
      req_we_r     <= req_we_s;
      req_ubhw_r   <= req_ubhw_s;
      req_din_r    <= req_din_s;
      victim_tag_r <= victim_tag_s;
      retry_r      <= retry_s;
    end
  end

  // Next-state logic and combinational array / memory / CPU controls
  always_comb begin
    state_s       = state_r;
    w_s           = w_r;
    req_addr_s    = req_addr_r;
    req_we_s      = req_we_r;
    req_ubhw_s    = req_ubhw_r;
    req_din_s     = req_din_r;
    victim_tag_s  = victim_tag_r;
    retry_s       = retry_r;
    cpu_ready_s   = 1'b0;
    cpu_dout_s    = 32'd0;
    cache_addr_s  = 32'd0;
    cache_load_s  = 1'b0;
    cache_store_s = 1'b0;
    cache_edit_s  = 1'b0;
    cache_ubhw_s  = UBHW_W;
    cache_din_s   = 32'd0;
    mem_req_s     = 1'b0;
    mem_we_s      = 1'b0;
    mem_addr_s    = 32'd0;
    mem_wdata_s   = 32'd0;

    case (state_r)
      ST_IDLE: begin
        // Parked fully at zero so the post-reset output state is all-zero.
        cache_ubhw_s = 3'b000;
        if (bus.cpu_req) begin
          req_addr_s = bus.cpu_addr;
          req_we_s   = bus.cpu_we;
          req_ubhw_s = bus.cpu_u_b_h_w;
          req_din_s  = bus.cpu_din;
          retry_s    = 1'b0;
          state_s    = ST_PROBE;
        end else begin
          state_s    = ST_IDLE;
        end
      end

      ST_PROBE: begin
        cache_addr_s = req_addr_r;
        cache_load_s = ~req_we_r;
        cache_edit_s = req_we_r;
        cache_ubhw_s = req_ubhw_r;
        cache_din_s  = req_din_r;
        state_s      = ST_CHECK;
      end

      ST_CHECK: begin
        if (bus.cache_hit) begin
          cpu_ready_s = 1'b1;
          cpu_dout_s  = bus.cache_dout;
          state_s     = ST_IDLE;
        end else begin
          victim_tag_s = bus.cache_tag;
          w_s          = WORD_FIRST;
          if (bus.cache_valid && bus.cache_dirty) begin
            state_s = ST_WB_RD;
          end else begin
            state_s = ST_FILL;
          end
        end
      end

      ST_WB_RD: begin
        cache_addr_s = wb_addr_s;
        state_s      = ST_WB_WR;
      end

      ST_WB_WR: begin
        // Keep addressing the victim word so the registered read data stays put.
        cache_addr_s = wb_addr_s;
        mem_req_s    = 1'b1;
        mem_we_s     = 1'b1;
        mem_addr_s   = wb_addr_s;
        mem_wdata_s  = bus.cache_dout;
        if (bus.mem_ack) begin
          w_s = w_r + WORD_STEP;
          if (w_r == WORD_LAST) begin
            state_s = ST_FILL;
          end else begin
            state_s = ST_WB_RD;
          end
        end else begin
          state_s = ST_WB_WR;
        end
      end

      ST_FILL: begin
        mem_req_s  = 1'b1;
        mem_addr_s = fill_addr_s;
        if (bus.mem_ack) begin
          cache_store_s = 1'b1;
          cache_addr_s  = fill_addr_s;
          cache_din_s   = bus.mem_rdata;
          w_s           = w_r + WORD_STEP;
          if (w_r == WORD_LAST) begin
            retry_s = 1'b1;
            state_s = ST_PROBE;
          end else begin
            state_s = ST_FILL;
          end
        end else begin
          state_s = ST_FILL;
        end
      end

      default: begin
        state_s = ST_IDLE;
        w_s     = WORD_FIRST;
      end
    endcase
  end

  assign bus.cpu_ready     = cpu_ready_s;
  assign bus.cpu_dout      = cpu_dout_s;
  assign bus.cache_addr    = cache_addr_s;
  assign bus.cache_load    = cache_load_s;
  assign bus.cache_store   = cache_store_s;
  assign bus.cache_edit    = cache_edit_s;
  assign bus.cache_invalid = 1'b0;
  assign bus.cache_u_b_h_w = cache_ubhw_s;
  assign bus.cache_din     = cache_din_s;
  assign bus.mem_req       = mem_req_s;
  assign bus.mem_we        = mem_we_s;
  assign bus.mem_addr      = mem_addr_s;
  assign bus.mem_wdata     = mem_wdata_s;

`ifdef CACHE_CTRL_STATS_EN
  logic hit_evt_s;
  logic miss_evt_s;
  logic wb_evt_s;

  // Retry probes after a fill are the tail of a miss, not a fresh hit.
  assign hit_evt_s  = (state_r == ST_CHECK) && bus.cache_hit && !retry_r;
  assign miss_evt_s = (state_r == ST_CHECK) && !bus.cache_hit;
  assign wb_evt_s   = miss_evt_s && bus.cache_valid && bus.cache_dirty;

  cache_ctrl_stats u_stats (
    .clk      (clk),
    .rst      (rst),
    .hit_evt  (hit_evt_s),
    .miss_evt (miss_evt_s),
    .wb_evt   (wb_evt_s),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
  );
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
  assign wb_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl with a 2-way LRU array model
// and a fixed-latency memory model.
module tb_cache_ctrl;
  import cache_pkg::*;

`ifdef CACHE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cache_ctrl_if bus ();

  cache_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
  );

  // ---------------- cache array model ----------------
  bit          arr_v [2][32];
  bit          arr_d [2][32];
  bit [22:0]   arr_t [2][32];
  bit [31:0]   arr_w [2][32][4];
  bit          lru   [32];
  logic        pre_en = 1'b0;
  int          pre_way, pre_set, pre_word;
  logic [22:0] pre_tag;
  logic [31:0] pre_data;

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] code, input logic [1:0] ofs);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*ofs +: 8];
    h = w[16*ofs[1] +: 16];
    case (code)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] d, input logic [2:0] code, input logic [1:0] ofs);
    logic [31:0] r;
    r = old;
    case (code[1:0])
      2'b00:   r[8*ofs +: 8] = d[7:0];
      2'b01:   r[16*ofs[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin : array_model
    int s, wd, hw, v;
    logic [22:0] tg;
    s  = int'(bus.cache_addr[8:4]);
    wd = int'(bus.cache_addr[3:2]);
    tg = bus.cache_addr[31:9];
    hw = -1;
    for (int k = 0; k < 2; k++) if (arr_v[k][s] && arr_t[k][s] == tg) hw = k;
    v = int'(lru[s]);
    if (pre_en) begin
      arr_v[pre_way][pre_set] <= 1'b1;
      arr_d[pre_way][pre_set] <= 1'b0;
      arr_t[pre_way][pre_set] <= pre_tag;
      arr_w[pre_way][pre_set][pre_word] <= pre_data;
    end else if (bus.cache_load || bus.cache_edit) begin
      if (hw >= 0) begin
        bus.cache_hit <= 1'b1;
        lru[s] <= (hw == 0);
        if (bus.cache_load) begin
          bus.cache_dout <= ld_ext(arr_w[hw][s][wd], bus.cache_u_b_h_w, bus.cache_addr[1:0]);
        end else begin
          arr_w[hw][s][wd] <= st_merge(arr_w[hw][s][wd], bus.cache_din, bus.cache_u_b_h_w, bus.cache_addr[1:0]);
          arr_d[hw][s] <= 1'b1;
        end
      end else begin
        bus.cache_hit   <= 1'b0;
        bus.cache_valid <= arr_v[v][s];
        bus.cache_dirty <= arr_d[v][s];
        bus.cache_tag   <= arr_t[v][s];
      end
    end else if (bus.cache_store) begin
      bus.cache_hit <= 1'b0;
      arr_v[v][s] <= 1'b1;
      arr_d[v][s] <= 1'b0;
      arr_t[v][s] <= tg;
      arr_w[v][s][wd] <= bus.cache_din;
    end else begin
      bus.cache_hit  <= 1'b0;
      bus.cache_dout <= arr_w[(hw >= 0) ? hw : v][s][wd];
    end
  end

  // ---------------- memory model ----------------
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } xact_t;
  xact_t     log_q[$];
  bit [31:0] mem [1024];
  bit        mem_wr [1024];
  int        mcnt = 0;
  int        mreq_cycles = 0;
  int        ack_cnt = 0;
  int        bad_fill = 0;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    if (a[31:4] == 28'h000_0020) return 32'h0000_00A0 + {30'd0, a[3:2]};
    else return 32'h5000_0000 | a;
  endfunction

  always @(posedge clk) begin : mem_model
    int i;
    logic [31:0] rd;
    i  = int'(bus.mem_addr[11:2]);
    rd = mem_wr[i] ? mem[i] : mem_init(bus.mem_addr);
    if (!bus.mem_req || bus.mem_ack) begin
      bus.mem_ack <= 1'b0;
      mcnt <= 0;
    end else if (mcnt == LAT - 1) begin
      bus.mem_ack <= 1'b1;
      bus.mem_rdata <= rd;
      if (bus.mem_we) begin
        mem[i] <= bus.mem_wdata;
        mem_wr[i] <= 1'b1;
      end
      log_q.push_back('{bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : rd});
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  always @(posedge clk) begin : monitors
    if (bus.mem_req === 1'b1) mreq_cycles <= mreq_cycles + 1;
    if (bus.mem_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    if (bus.cache_store === 1'b1 && (bus.cache_u_b_h_w !== 3'b010 || bus.cache_invalid !== 1'b0)) bad_fill <= bad_fill + 1;
  end

  // ---------------- helpers ----------------
  logic        p_load, p_edit;
  logic [2:0]  p_code;
  logic [31:0] p_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int way, input int set, input logic [22:0] tag, input int word, input logic [31:0] data);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_way = way; pre_set = set; pre_tag = tag; pre_word = word; pre_data = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic cpu_op(input string tag, input logic we, input logic [31:0] addr, input logic [2:0] code,
                        input logic [31:0] din, output logic [31:0] dout, output int cyc);
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_u_b_h_w = code; bus.cpu_din = din;
    cyc = 0;
    dout = 32'hxxxx_xxxx;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        p_load = bus.cache_load; p_edit = bus.cache_edit; p_code = bus.cache_u_b_h_w; p_din = bus.cache_din;
      end
      if (bus.cpu_ready === 1'b1) begin
        cyc = n;
        dout = bus.cpu_dout;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    checks++;
    assert (cyc != 0) else begin
      errors++;
      $error("FAIL %s_timeout: observed no cpu_ready expected cpu_ready within 200 cycles", tag);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {26'd0, bus.cpu_ready, bus.cache_load, bus.cache_store, bus.cache_edit,
                        bus.cache_invalid, bus.mem_req, bus.mem_we}, 32'd0);
    chk({tag, "_caddr"}, bus.cache_addr, 32'd0);
    chk({tag, "_cubhw"}, {29'd0, bus.cache_u_b_h_w}, 32'd0);
    chk({tag, "_cdin"}, bus.cache_din, 32'd0);
    chk({tag, "_maddr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mwdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_dout"}, bus.cpu_dout, 32'd0);
    chk({tag, "_state"}, 32'(dut.state_r), 32'(ST_IDLE));
    chk({tag, "_cnt"}, hit_cnt | miss_cnt | wb_cnt, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    int          c, s, m0, a0;
    bit          got;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd0; bus.cpu_u_b_h_w = 3'b000; bus.cpu_din = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst = 1'b0;

    preload(0, 16, 23'd0, 0, 32'h1122_3344);
    preload(0, 16, 23'd0, 1, 32'hCAFE_0104);
    preload(0, 1, 23'd0, 0, 32'h80FF_FFFF);

    // clean miss into empty set 0
    s = log_q.size();
    cpu_op("clean", 1'b0, 32'h0000_0200, UBHW_W, 32'd0, d, c);
    chk("clean_dout", d, 32'h0000_00A0);
    chk("clean_cycles", c, 16);
    chk("clean_nxact", log_q.size() - s, 4);
    for (int k = 0; k < 4; k++) begin
      chk("clean_we", {31'd0, log_q[s+k].we}, 32'd0);
      chk("clean_addr", log_q[s+k].addr, 32'h0000_0200 + 32'(4*k));
      chk("clean_data", log_q[s+k].data, 32'h0000_00A0 + 32'(k));
    end
    chk("clean_miss_cnt", miss_cnt, STATS ? 32'd1 : 32'd0);
    chk("clean_hit_cnt", hit_cnt, 32'd0);

    // load hit on preloaded line
    m0 = mreq_cycles;
    cpu_op("hit", 1'b0, 32'h0000_0104, UBHW_W, 32'd0, d, c);
    chk("hit_dout", d, 32'hCAFE_0104);
    chk("hit_cycles", c, 2);
    chk("hit_no_mem", mreq_cycles - m0, 0);
    chk("hit_cnt", hit_cnt, STATS ? 32'd1 : 32'd0);

    // store byte hit, then read back the merged word
    cpu_op("sb", 1'b1, 32'h0000_0101, UBHW_B, 32'h0000_0055, d, c);
    chk("sb_cycles", c, 2);
    chk("sb_probe", {26'd0, p_load, p_edit, 1'b0, p_code}, {26'd0, 1'b0, 1'b1, 1'b0, 3'b000});
    chk("sb_probe_din", p_din, 32'h0000_0055);
    cpu_op("sb_rd", 1'b0, 32'h0000_0100, UBHW_W, 32'd0, d, c);
    chk("sb_readback", d, 32'h1122_5544);

    // signed / unsigned sub-word loads
    cpu_op("lb", 1'b0, 32'h0000_0013, UBHW_B, 32'd0, d, c);
    chk("lb", d, 32'hFFFF_FF80);
    cpu_op("lbu", 1'b0, 32'h0000_0013, UBHW_BU, 32'd0, d, c);
    chk("lbu", d, 32'h0000_0080);
    cpu_op("lh", 1'b0, 32'h0000_0012, UBHW_H, 32'd0, d, c);
    chk("lh", d, 32'hFFFF_80FF);
    cpu_op("lhu", 1'b0, 32'h0000_0012, UBHW_HU, 32'd0, d, c);
    chk("lhu", d, 32'h0000_80FF);

    // fill second way of set 0, dirty the first, then evict it
    cpu_op("fill2", 1'b0, 32'h0000_0400, UBHW_W, 32'd0, d, c);
    chk("fill2_dout", d, 32'h5000_0400);
    cpu_op("sw", 1'b1, 32'h0000_0204, UBHW_W, 32'hDEAD_BEEF, d, c);
    chk("sw_cycles", c, 2);
    cpu_op("touch", 1'b0, 32'h0000_0400, UBHW_W, 32'd0, d, c);
    chk("touch_cycles", c, 2);
    s = log_q.size();
    cpu_op("dirty", 1'b0, 32'h0000_0600, UBHW_W, 32'd0, d, c);
    chk("dirty_dout", d, 32'h5000_0600);
    chk("dirty_cycles", c, 32);
    chk("dirty_nxact", log_q.size() - s, 8);
    for (int k = 0; k < 4; k++) begin
      chk("wb_we", {31'd0, log_q[s+k].we}, 32'd1);
      chk("wb_addr", log_q[s+k].addr, 32'h0000_0200 + 32'(4*k));
      chk("wb_data", log_q[s+k].data, (k == 1) ? 32'hDEAD_BEEF : 32'h0000_00A0 + 32'(k));
      chk("rf_we", {31'd0, log_q[s+4+k].we}, 32'd0);
      chk("rf_addr", log_q[s+4+k].addr, 32'h0000_0600 + 32'(4*k));
    end
    chk("wb_cnt", wb_cnt, STATS ? 32'd1 : 32'd0);
    chk("miss_cnt_total", miss_cnt, STATS ? 32'd3 : 32'd0);
    chk("hit_cnt_total", hit_cnt, STATS ? 32'd9 : 32'd0);

    // reset after the second fill word has been accepted
    a0 = ack_cnt;
    got = 1'b0;
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0800; bus.cpu_u_b_h_w = UBHW_W;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (ack_cnt - a0 >= 2) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL midfill_acks: observed %0d acks expected 2", ack_cnt - a0);
    end
    chk("midfill_busy", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    chk_quiet("midrst");
    rst = 1'b0;
    cpu_op("reissue", 1'b0, 32'h0000_0804, UBHW_W, 32'd0, d, c);
    chk("reissue_dout", d, 32'h5000_0804);
    chk("reissue_cycles", c, 2);
    chk("reissue_hit_cnt", hit_cnt, STATS ? 32'd1 : 32'd0);
    chk("fill_width", bad_fill, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
